// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and MEM-stage
// load/store, sequencing each access through issue, read-latency wait and ack.
module mem_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic {PORT_INST, PORT_DATA} port_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  port_t       last_grant_q, last_grant_d;
  port_t       grant_q, grant_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        pick_data;
  logic        issue;
  logic        capture;

  // Data wins unless the fetch port is alone or data was served last.
  assign pick_data = data_req & (~inst_req | (last_grant_q == PORT_INST));
  // Reset in the issue cycle suppresses the RAM enable entirely.
  assign issue     = (state_q == IDLE) & (inst_req | data_req) & ~rst;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    capture      = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 4'b0000;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          mem_en       = 1'b1;
          grant_d      = pick_data ? PORT_DATA : PORT_INST;
          last_grant_d = grant_d;
          if (pick_data) begin
            mem_we    = data_we;
            mem_addr  = {data_addr[31:2], 2'b00};
            mem_wdata = data_wdata;
          end else begin
            mem_addr  = {inst_addr[31:2], 2'b00};
          end
          if (pick_data && (data_we != 4'b0000)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= PORT_INST;
      grant_q      <= PORT_INST;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      if (capture && grant_q == PORT_DATA) data_rdata_q <= mem_rdata;
      if (capture && grant_q == PORT_INST) inst_rdata_q <= mem_rdata;
    end
  end

  assign inst_ack   = (state_q == DONE) & (grant_q == PORT_INST) & ~rst;
  assign data_ack   = (state_q == DONE) & (grant_q == PORT_DATA) & ~rst;
  assign stall_if   = inst_req & ~inst_ack;
  assign stall_mem  = data_req & ~data_ack;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // Byte selection is by write enables only; the low address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};

endmodule
